// File: rtl/image_stream_decryptor.sv
// Walks the encrypted image ROM one byte per 3 clocks, XORs each byte with a
// 16-bit Galois LFSR keystream and writes the plaintext into the decryption RAM.
module image_stream_decryptor #(
  parameter int          ADDR_W       = 15,
  parameter int          DATA_W       = 8,
  parameter int          IMG_BYTES    = 19200,
  parameter logic [15:0] DEFAULT_SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              enable,
  input  logic [15:0]       key,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_BYTES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [15:0]       lfsr;
  logic [15:0]       lfsr_next;

  assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Strobe is gated by enable so a paused WRITE never commits.
  assign wr_en = (state == S_WRITE) && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      lfsr     <= DEFAULT_SEED;
      rom_addr <= '0;
      wr_addr  <= '0;
      wr_data  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            idx      <= '0;
            rom_addr <= '0;
            lfsr     <= (key == 16'h0000) ? DEFAULT_SEED : key;
            busy     <= 1'b1;
            done     <= 1'b0;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (enable) state <= S_WAIT;
        end
        S_WAIT: begin
          // ROM address is stable across a pause, so capturing late is safe.
          if (enable) begin
            wr_data <= rom_data ^ lfsr[DATA_W-1:0];
            wr_addr <= idx;
            state   <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (enable) begin
            lfsr <= lfsr_next;
            if (idx == LAST_IDX) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              idx      <= idx + 1'b1;
              rom_addr <= idx + 1'b1;
              state    <= S_FETCH;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_image_stream_decryptor.sv
// Randomized bench for image_stream_decryptor with a keystream reference model
// and directed cases for latency, pause, mid-run reset and start-while-busy.
module tb_image_stream_decryptor;
  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        enable = 1'b1;
  logic [15:0] key = 16'h0000;
  logic [14:0] rom_addr, wr_addr;
  logic [7:0]  rom_data, wr_data;
  logic        wr_en, busy, done;

  logic [7:0]  rom_mem [N];
  logic [7:0]  saved [N];
  logic [7:0]  wq_data [$];
  int          wq_addr [$];
  int          wq_rel  [$];
  int          done_rel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  image_stream_decryptor #(.IMG_BYTES(N)) u_dut (
    .clk(clk), .rst(rst), .start(start), .enable(enable), .key(key),
    .rom_addr(rom_addr), .rom_data(rom_data), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .busy(busy), .done(done)
  );

  // 1-cycle registered ROM
  always @(posedge clk) rom_data <= rom_mem[rom_addr[1:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Keystream byte for pixel n: seed, then n Galois steps.
  function automatic logic [7:0] ks(input logic [15:0] k, input int n);
    logic [15:0] l;
    l = (k == 16'h0000) ? 16'hACE1 : k;
    for (int s = 0; s < n; s++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    return l[7:0];
  endfunction

  // mode 0: enable=1, 1: random enable, 2: 5-cycle pause in 2nd WRITE, 3: start while busy
  task automatic run(input logic [15:0] k, input int mode, input string tag);
    int  rel;
    int  lim;
    bit  fin;
    fin = 1'b0;
    wq_data.delete(); wq_addr.delete(); wq_rel.delete();
    done_rel = -1;
    @(negedge clk); key = k; start = 1'b1; enable = 1'b1;
    @(negedge clk); start = 1'b0;
    for (rel = 0; rel < 300 && !fin; rel++) begin
      if (rel > 0) @(negedge clk);
      case (mode)
        1:       enable = ($urandom_range(0, 2) != 0);
        2:       enable = !(rel >= 5 && rel <= 9);
        default: enable = 1'b1;
      endcase
      start = (mode == 3 && rel == 4);
      if (mode == 3 && rel == 4) key = 16'h1234;
      #1;
      if (rel == 0) chk({tag, " busy_rel0"}, busy, 1);
      if (mode == 2 && rel >= 5 && rel <= 9) begin
        chk({tag, " pause_wr_en"}, wr_en, 0);
        chk({tag, " pause_wr_addr"}, wr_addr, 1);
        chk({tag, " pause_wr_data"}, wr_data, rom_mem[1] ^ ks(k, 1));
      end
      if (wr_en) begin
        wq_data.push_back(wr_data);
        wq_addr.push_back(int'(wr_addr));
        wq_rel.push_back(rel);
      end
      if (done) begin
        done_rel = rel;
        fin = 1'b1;
        chk({tag, " busy_at_done"}, busy, 0);
      end
    end
    start = 1'b0; enable = 1'b1;
    if (!fin) chk({tag, " done_timeout"}, 0, 1);
    chk({tag, " nwrites"}, wq_data.size(), N);
    lim = (wq_data.size() < N) ? wq_data.size() : N;
    for (int i = 0; i < lim; i++) begin
      chk({tag, " addr"}, wq_addr[i], i);
      chk({tag, " data"}, wq_data[i], rom_mem[i] ^ ks(k, i));
      if (mode == 0 || mode == 3) chk({tag, " wr_cycle"}, wq_rel[i], 2 + 3 * i);
    end
    if (fin && (mode == 0 || mode == 3)) chk({tag, " done_cycle"}, done_rel, 3 * N);
    else if (fin && lim > 0) chk({tag, " done_after_last"}, done_rel, wq_rel[lim-1] + 1);
    repeat (3) @(negedge clk);
    #1;
    chk({tag, " done_hold"}, done, 1);
    chk({tag, " busy_idle"}, busy, 0);
    chk({tag, " no_stray_wr"}, wr_en, 0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) rom_mem[i] = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    chk("rst rom_addr", rom_addr, 0);
    chk("rst wr_en", wr_en, 0);
    chk("rst wr_addr", wr_addr, 0);
    chk("rst wr_data", wr_data, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst = 1'b0;

    // zero ROM, default seed
    run(16'h0000, 0, "zero");
    if (wq_data.size() >= 4) begin
      chk("zero ks0", wq_data[0], 8'hE1);
      chk("zero ks1", wq_data[1], 8'h70);
      chk("zero ks2", wq_data[2], 8'h38);
      chk("zero ks3", wq_data[3], 8'h9C);
    end

    // encrypt then decrypt round trip
    rom_mem[0] = 8'hFF;
    for (int i = 1; i < N; i++) rom_mem[i] = 8'($urandom);
    for (int i = 0; i < N; i++) saved[i] = rom_mem[i];
    run(16'h0000, 0, "ff");
    if (wq_data.size() >= 1) chk("ff byte0", wq_data[0], 8'h1E);
    if (wq_data.size() == N) begin
      for (int i = 0; i < N; i++) rom_mem[i] = wq_data[i];
      run(16'h0000, 0, "pass2");
      if (wq_data.size() == N)
        for (int i = 0; i < N; i++) chk("pass2 plain", wq_data[i], saved[i]);
    end

    // pause in WRITE
    for (int i = 0; i < N; i++) rom_mem[i] = 8'h00;
    run(16'h0000, 2, "pause");
    if (wq_data.size() >= 2) chk("pause ks1", wq_data[1], 8'h70);

    // start while busy, key=1
    run(16'h0001, 3, "busy_start");
    if (wq_data.size() >= 2) begin
      chk("key1 ks0", wq_data[0], 8'h01);
      chk("key1 ks1", wq_data[1], 8'h00);
    end

    // reset after two writes
    @(negedge clk); key = 16'h5A5A; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("midrst rom_addr", rom_addr, 0);
    chk("midrst wr_en", wr_en, 0);
    chk("midrst wr_addr", wr_addr, 0);
    chk("midrst wr_data", wr_data, 0);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    rst = 1'b0;
    run(16'h0000, 0, "post_rst");
    if (wq_data.size() >= 1) chk("post_rst ks0", wq_data[0], 8'hE1);

    // random keys, data and enable
    for (int r = 0; r < 15; r++) begin
      logic [15:0] k;
      for (int i = 0; i < N; i++) rom_mem[i] = 8'($urandom);
      k = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      run(k, (r % 3 == 0) ? 0 : 1, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
